register_context_engine: RTL and testbench
==========================================

# register_context_engine

Sequential save/restore engine that copies the integer register file into the shadow register bank (save) or back (restore), one register per cycle. It sits between the CPU register bank and the shadow bank and drives one read port and the write port of each. It is used for trap and context-switch entry and exit. Register 0 is never copied, since both banks hold it at zero.

## Interface
- REG_NUM, 32, number of registers per bank (power of two, ≥4)
- DATA_WIDTH, 64, register width in bits
- AW (local), $clog2(REG_NUM), address width
- clk  in  1  clock; all engine state updates on posedge
- reset  in  1  asynchronous, active-low reset
- save_req  in  1  start copy main→shadow (sampled in IDLE only)
- restore_req  in  1  start copy shadow→main (sampled in IDLE only)
- stall  in  1  freeze copy progress for this cycle
- busy  out  1  copy in progress
- done  out  1  one-cycle completion pulse
- main_rd_addr  out  AW  main bank read address
- main_rd_data  in  DATA_WIDTH  main bank combinational read data
- main_wr_addr / main_wr_data / main_wr_en  out  AW / DATA_WIDTH / 1  main bank write port
- sh_rd_addr  out  AW  shadow bank read address
- sh_rd_data  in  DATA_WIDTH  shadow bank combinational read data
- sh_wr_addr / sh_wr_data / sh_wr_en  out  AW / DATA_WIDTH / 1  shadow bank write port

## Operation
- FSM states: IDLE, COPY, DRAIN. A direction flag `dir` is registered (0 = save, 1 = restore). The index counter `idx` is AW bits wide.
- IDLE:
  - If save_req or restore_req is high at posedge: latch dir (save wins when both are high), set idx←1 and busy←1, go to COPY.
  - Otherwise hold.
- COPY, with stall=0 at posedge:
  - Source read address = idx, driven combinationally from the idx register.
  - Destination write registers: wr_addr←idx, wr_data←source rd_data, wr_en←1.
  - idx←idx+1.
  - If idx==REG_NUM-1, go to DRAIN.
- COPY, with stall=1 at posedge: wr_en←0, idx holds, state holds.
- DRAIN:
  - The final write is presented this cycle.
  - At posedge: wr_en←0, busy←0, done←1, go to IDLE.
  - stall is ignored in DRAIN.
- done is high exactly one cycle, then returns to 0.
- Source/destination selection:
  - Save: main is the source, shadow is the destination.
  - Restore: shadow is the source, main is the destination.
- Non-selected port outputs:
  - The source side's wr_en is 0.
  - The destination side's rd_addr is 0.
  - All rd_addr outputs are 0 in IDLE and DRAIN.
- Requests while busy are ignored and are not queued. A request in the done cycle is accepted (FSM is in IDLE).
- Address 0 is never read or written. idx never wraps: the DRAIN transition occurs before idx overflows.

## Timing
- Reset values (async, on reset=0):
  - State IDLE, idx 0, dir 0.
  - busy 0, done 0.
  - All wr_en 0; all wr_addr, wr_data and rd_addr 0.
- Reset mid-copy:
  - Aborts immediately; no done pulse.
  - Registers already written in the destination keep their new values; the rest keep their old values.
- Acceptance at edge E0: busy is high from E0. Register i's write enable is high in the cycle following edge E(i), with no stall.
- Banks capture on negedge, so each write lands mid-cycle. A destination read later in the same cycle returns the new value.
- Unstalled latency: busy falls and done rises at edge E(REG_NUM) (32 edges at default). Each stalled cycle adds one cycle.
- Throughput: one register per unstalled cycle. Sustained wr_en is high for REG_NUM-1 consecutive cycles.

## Test plan
- Save:
  - Stimulus: main x1..x31 = 0x1000+i, shadow cleared, pulse save_req for 1 cycle.
  - Required: busy high for 32 cycles; shadow x(i)=0x1000+i for all i; shadow x0=0; one done pulse exactly 32 edges after acceptance; main_wr_en never asserted.
- Restore:
  - Stimulus: shadow x(i)=~i, main cleared, assert restore_req.
  - Required: main x(i)=~i for i=1..31; sh_wr_en never asserted; writes appear in ascending address order, 1 through 31.
- Simultaneous requests and busy behaviour:
  - save_req and restore_req both high → save performed.
  - restore_req pulsed at cycle 10 of busy → ignored; no second copy.
  - Request held high through the done cycle → a second copy starts at the edge ending the done cycle.
- Stall:
  - Stimulus: stall high for 3 cycles at idx=5, then 1 cycle at idx=20.
  - Required: wr_en low during stalled cycles; no address skipped or duplicated; done at edge E(36).
- Async reset mid-copy:
  - Stimulus: drop reset at idx=12 during a save.
  - Required: busy, done and all wr_en go to 0 immediately, without waiting for a clock edge; shadow x1..x11 updated; shadow x12..x31 unchanged; after release, FSM is in IDLE and accepts a new save.

Source files
------------

// File: rtl/register_context_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : register_context_engine_if
//  Purpose  : Request/status handshake and the read/write ports of both the
//             main and the shadow register banks, bundled for the save/restore
//             engine.
//  Revision : 1.0  initial release
// ============================================================================
interface register_context_engine_if #(
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 64
);
  localparam int AW = $clog2(REG_NUM);

  // Request / status handshake
  logic                  save_req;
  logic                  restore_req;
  logic                  stall;
  logic                  busy;
  logic                  done;

  // Main bank ports
  logic [AW-1:0]         main_rd_addr;
  logic [DATA_WIDTH-1:0] main_rd_data;
  logic [AW-1:0]         main_wr_addr;
  logic [DATA_WIDTH-1:0] main_wr_data;
  logic                  main_wr_en;

  // Shadow bank ports
  logic [AW-1:0]         sh_rd_addr;
  logic [DATA_WIDTH-1:0] sh_rd_data;
  logic [AW-1:0]         sh_wr_addr;
  logic [DATA_WIDTH-1:0] sh_wr_data;
  logic                  sh_wr_en;

  // Engine side
  modport master (
    input  save_req, restore_req, stall,
    input  main_rd_data, sh_rd_data,
    output busy, done,
    output main_rd_addr, main_wr_addr, main_wr_data, main_wr_en,
    output sh_rd_addr, sh_wr_addr, sh_wr_data, sh_wr_en
  );

  // Requester / bank side
  modport slave (
    output save_req, restore_req, stall,
    output main_rd_data, sh_rd_data,
    input  busy, done,
    input  main_rd_addr, main_wr_addr, main_wr_data, main_wr_en,
    input  sh_rd_addr, sh_wr_addr, sh_wr_data, sh_wr_en
  );
endinterface
`default_nettype wire

// File: rtl/register_context_engine.sv
`default_nettype none
// ============================================================================
//  Module   : register_context_engine
//  Purpose  : Copies registers 1..REG_NUM-1 from the main bank into the shadow
//             bank (save) or back (restore), one register per unstalled cycle.
//             Register 0 is hard-wired zero in both banks and is skipped.
//  Revision : 1.0  initial release
// ============================================================================
module register_context_engine #(
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 64
) (
  input wire clk,
  input wire reset,
  register_context_engine_if.master bus
);

  localparam int AW = $clog2(REG_NUM);
  localparam logic [AW-1:0] c_first_idx = AW'(1);
  localparam logic [AW-1:0] c_last_idx  = AW'(REG_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COPY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [AW-1:0]         r_idx;
  logic                  r_dir;          // 0 = save (main->shadow), 1 = restore
  logic                  r_busy;
  logic                  r_done;

  logic [AW-1:0]         r_main_wr_addr;
  logic [DATA_WIDTH-1:0] r_main_wr_data;
  logic                  r_main_wr_en;
  logic [AW-1:0]         r_sh_wr_addr;
  logic [DATA_WIDTH-1:0] r_sh_wr_data;
  logic                  r_sh_wr_en;

  logic                  w_copying;

  // Sequencer: accepts a request, walks idx across the bank, then drains the last write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_dir          <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_main_wr_addr <= '0;
      r_main_wr_data <= '0;
      r_main_wr_en   <= 1'b0;
      r_sh_wr_addr   <= '0;
      r_sh_wr_data   <= '0;
      r_sh_wr_en     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_main_wr_en <= 1'b0;
          r_sh_wr_en   <= 1'b0;
          if (bus.save_req || bus.restore_req) begin
            // Save has priority when both requests arrive together
            r_dir   <= ~bus.save_req;
            r_idx   <= c_first_idx;
            r_busy  <= 1'b1;
            r_state <= S_COPY;
          end
        end

        S_COPY: begin
          if (bus.stall) begin
            r_main_wr_en <= 1'b0;
            r_sh_wr_en   <= 1'b0;
          end else begin
            if (r_dir) begin
              r_main_wr_addr <= r_idx;
              r_main_wr_data <= bus.sh_rd_data;
              r_main_wr_en   <= 1'b1;
              r_sh_wr_en     <= 1'b0;
            end else begin
              r_sh_wr_addr   <= r_idx;
              r_sh_wr_data   <= bus.main_rd_data;
              r_sh_wr_en     <= 1'b1;
              r_main_wr_en   <= 1'b0;
            end
            // idx stops at the top register instead of wrapping back to 0
            if (r_idx == c_last_idx) begin
              r_state <= S_DRAIN;
            end else begin
              r_idx <= r_idx + AW'(1);
            end
          end
        end

        S_DRAIN: begin
          // The top register's write is on the bus during this state; stall is ignored
          r_main_wr_en <= 1'b0;
          r_sh_wr_en   <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b1;
          r_state      <= S_IDLE;
        end

        default: begin
          r_main_wr_en <= 1'b0;
          r_sh_wr_en   <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  // Only the source bank is addressed, and only while copying
  assign w_copying        = (r_state == S_COPY);
  assign bus.main_rd_addr = (w_copying && !r_dir) ? r_idx : '0;
  assign bus.sh_rd_addr   = (w_copying &&  r_dir) ? r_idx : '0;

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.main_wr_addr = r_main_wr_addr;
  assign bus.main_wr_data = r_main_wr_data;
  assign bus.main_wr_en   = r_main_wr_en;
  assign bus.sh_wr_addr   = r_sh_wr_addr;
  assign bus.sh_wr_data   = r_sh_wr_data;
  assign bus.sh_wr_en     = r_sh_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_register_context_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_context_engine
//  Purpose  : Bench for the register save/restore engine: behavioural bank
//             model, copy-progress reference model and per-cycle comparison.
//  Revision : 1.0  initial release
// ============================================================================
module tb_register_context_engine;

  localparam int RN = 32;
  localparam int DW = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  register_context_engine_if #(.REG_NUM(RN), .DATA_WIDTH(DW)) bus ();

  register_context_engine #(.REG_NUM(RN), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Bank contents seen by the DUT, and the reference contents the model expects
  logic [DW-1:0] act_main [RN];
  logic [DW-1:0] act_sh   [RN];
  logic [DW-1:0] ref_main [RN];
  logic [DW-1:0] ref_sh   [RN];

  assign bus.main_rd_data = act_main[bus.main_rd_addr];
  assign bus.sh_rd_data   = act_sh[bus.sh_rd_addr];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Banks capture on the falling edge
  initial forever begin
    @(negedge clk);
    if (bus.main_wr_en) act_main[bus.main_wr_addr] = bus.main_wr_data;
    if (bus.sh_wr_en)   act_sh[bus.sh_wr_addr]     = bus.sh_wr_data;
  end

  // Reference model: tracks how many registers of the current copy are done
  bit          m_active, m_dir, m_busy, m_done, m_wen;
  int          m_k;          // registers already copied; next one is m_k+1
  int          m_waddr;
  logic [DW-1:0] m_wdata;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_active = 0; m_dir = 0; m_k = 0; m_busy = 0; m_done = 0; m_wen = 0;
    end else begin
      m_done = 0;
      if (!m_active) begin
        m_wen = 0;
        if (bus.save_req || bus.restore_req) begin
          m_active = 1; m_busy = 1; m_k = 0;
          m_dir = !bus.save_req;
        end
      end else if (m_k == RN - 1) begin
        m_active = 0; m_busy = 0; m_done = 1; m_wen = 0;
      end else if (bus.stall) begin
        m_wen = 0;
      end else begin
        m_k++;
        m_wen   = 1;
        m_waddr = m_k;
        m_wdata = m_dir ? ref_sh[m_k] : ref_main[m_k];
        if (m_dir) ref_main[m_k] = m_wdata;
        else       ref_sh[m_k]   = m_wdata;
      end
    end
  end

  // Observation counters
  int cyc = 0, starts = 0, done_cnt = 0, busy_cycles = 0;
  int main_wr_cnt = 0, sh_wr_cnt = 0, d_start = 0, d_done = 0;
  bit prev_busy = 0;
  int wlog[$];

  // Per-cycle comparison against the model, sampled 1 time unit after the edge
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("main_wr_en", bus.main_wr_en, m_wen && m_dir);
      chk("sh_wr_en", bus.sh_wr_en, m_wen && !m_dir);
      chk("main_rd_addr", bus.main_rd_addr, (m_active && m_k < RN-1 && !m_dir) ? m_k+1 : 0);
      chk("sh_rd_addr", bus.sh_rd_addr, (m_active && m_k < RN-1 && m_dir) ? m_k+1 : 0);
      if (m_wen && m_dir) begin
        chk("main_wr_addr", bus.main_wr_addr, m_waddr);
        chk("main_wr_data", bus.main_wr_data, m_wdata);
      end
      if (m_wen && !m_dir) begin
        chk("sh_wr_addr", bus.sh_wr_addr, m_waddr);
        chk("sh_wr_data", bus.sh_wr_data, m_wdata);
      end
      if (bus.main_wr_en) begin main_wr_cnt++; wlog.push_back(int'(bus.main_wr_addr)); end
      if (bus.sh_wr_en)   begin sh_wr_cnt++;   wlog.push_back(int'(bus.sh_wr_addr));   end
      if (bus.busy && !prev_busy) begin starts++; d_start = cyc; end
      if (bus.busy) busy_cycles++;
      if (bus.done) begin done_cnt++; d_done = cyc; end
      prev_busy = bus.busy;
    end
  end

  task automatic clr();
    wlog.delete();
    starts = 0; busy_cycles = 0; main_wr_cnt = 0; sh_wr_cnt = 0;
  endtask

  task automatic set_reg(input bit shadow, input int i, input logic [DW-1:0] v);
    if (shadow) begin act_sh[i] = v;   ref_sh[i] = v;   end
    else        begin act_main[i] = v; ref_main[i] = v; end
  endtask

  task automatic start(input bit s, input bit r);
    @(negedge clk);
    bus.save_req = s; bus.restore_req = r;
    @(negedge clk);
    bus.save_req = 0; bus.restore_req = 0;
  endtask

  task automatic wait_done(input int bound);
    int n0;
    int n;
    n0 = done_cnt;
    n  = 0;
    while (done_cnt == n0 && n < bound) begin @(negedge clk); n++; end
    chk("done_seen", done_cnt != n0, 1);
  endtask

  task automatic chk_banks();
    for (int i = 0; i < RN; i++) begin
      chk("main_bank", act_main[i], ref_main[i]);
      chk("sh_bank", act_sh[i], ref_sh[i]);
    end
  endtask

  task automatic chk_order();
    chk("wr_count", wlog.size(), RN - 1);
    for (int i = 0; i < wlog.size(); i++) chk("wr_order", wlog[i], i + 1);
  endtask

  initial begin
    bus.save_req = 0; bus.restore_req = 0; bus.stall = 0;
    for (int i = 0; i < RN; i++) begin set_reg(0, i, '0); set_reg(1, i, '0); end

    // Reset state
    #1 reset = 0;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_main_wr_en", bus.main_wr_en, 0);
    chk("rst_sh_wr_en", bus.sh_wr_en, 0);
    chk("rst_main_rd_addr", bus.main_rd_addr, 0);
    chk("rst_sh_rd_addr", bus.sh_rd_addr, 0);
    chk("rst_main_wr_addr", bus.main_wr_addr, 0);
    chk("rst_sh_wr_data", bus.sh_wr_data, 0);
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);

    // Save: main xi = 0x1000+i, shadow cleared
    for (int i = 1; i < RN; i++) set_reg(0, i, 64'h1000 + 64'(i));
    clr();
    start(1, 0);
    wait_done(100);
    repeat (2) @(negedge clk);
    chk("save_latency", d_done - d_start, 32);
    chk("save_busy_cycles", busy_cycles, 32);
    chk("save_main_wr_en", main_wr_cnt, 0);
    chk("save_sh0", act_sh[0], 0);
    for (int i = 1; i < RN; i++) chk("save_sh_lit", act_sh[i], 64'h1000 + 64'(i));
    chk_order();
    chk_banks();

    // Restore: shadow xi = ~i, main cleared
    for (int i = 1; i < RN; i++) begin set_reg(1, i, ~64'(i)); set_reg(0, i, '0); end
    clr();
    start(0, 1);
    wait_done(100);
    repeat (2) @(negedge clk);
    chk("restore_sh_wr_en", sh_wr_cnt, 0);
    for (int i = 1; i < RN; i++) chk("restore_main_lit", act_main[i], ~64'(i));
    chk_order();
    chk_banks();

    // Both requests: save wins
    for (int i = 1; i < RN; i++) begin set_reg(0, i, 64'hA000 + 64'(i)); set_reg(1, i, 64'h5); end
    clr();
    start(1, 1);
    wait_done(100);
    repeat (2) @(negedge clk);
    chk("both_sh_writes", sh_wr_cnt, 31);
    chk("both_main_writes", main_wr_cnt, 0);
    chk("both_sh7_lit", act_sh[7], 64'hA007);
    chk_banks();

    // Restore request during busy cycle 10 is dropped
    clr();
    start(1, 0);
    repeat (9) @(negedge clk);
    bus.restore_req = 1;
    @(negedge clk);
    bus.restore_req = 0;
    wait_done(100);
    repeat (4) @(negedge clk);
    chk("ignored_starts", starts, 1);
    chk("ignored_busy", bus.busy, 0);
    chk("ignored_main_writes", main_wr_cnt, 0);

    // Request held through the done cycle starts a second copy
    clr();
    @(negedge clk);
    bus.save_req = 1;
    wait_done(100);
    @(posedge clk);
    #2;
    chk("held_busy_again", bus.busy, 1);
    chk("held_starts", starts, 2);
    @(negedge clk);
    bus.save_req = 0;
    wait_done(100);
    repeat (2) @(negedge clk);
    chk_banks();

    // Stall 3 cycles at idx=5 and 1 cycle at idx=20
    for (int i = 1; i < RN; i++) set_reg(0, i, 64'h3000 + 64'(i));
    clr();
    start(1, 0);
    repeat (4) @(negedge clk);
    bus.stall = 1;
    repeat (3) @(negedge clk);
    bus.stall = 0;
    repeat (15) @(negedge clk);
    bus.stall = 1;
    @(negedge clk);
    bus.stall = 0;
    wait_done(100);
    repeat (2) @(negedge clk);
    chk("stall_latency", d_done - d_start, 36);
    chk_order();
    chk_banks();

    // Asynchronous reset while idx=12 during a save
    for (int i = 1; i < RN; i++) begin
      set_reg(0, i, 64'h2000 + 64'(i));
      set_reg(1, i, 64'hDEAD0000 + 64'(i));
    end
    clr();
    start(1, 0);
    repeat (11) @(negedge clk);
    #1 reset = 0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_sh_wr_en", bus.sh_wr_en, 0);
    chk("arst_main_wr_en", bus.main_wr_en, 0);
    @(negedge clk);
    reset = 1;
    for (int i = 1; i < RN; i++)
      chk("arst_sh_lit", act_sh[i], (i < 12) ? 64'h2000 + 64'(i) : 64'hDEAD0000 + 64'(i));
    chk_banks();
    clr();
    start(1, 0);
    wait_done(100);
    repeat (2) @(negedge clk);
    chk("arst_resave_starts", starts, 1);
    chk("arst_sh31_lit", act_sh[31], 64'h201F);
    chk_banks();

    // Randomised copies with random stalls and stray requests while busy
    for (int t = 0; t < 8; t++) begin
      int kind;
      int n0;
      int n;
      for (int i = 1; i < RN; i++) begin
        set_reg(0, i, {$urandom, $urandom});
        set_reg(1, i, {$urandom, $urandom});
      end
      kind = $urandom_range(0, 2);
      clr();
      n0 = done_cnt;
      start(kind != 1, kind != 0);
      n = 0;
      while (done_cnt == n0 && n < 300) begin
        bus.stall       = ($urandom_range(0, 3) == 0);
        bus.restore_req = (n < 20) && ($urandom_range(0, 7) == 0);
        bus.save_req    = (n < 20) && ($urandom_range(0, 7) == 0);
        @(negedge clk);
        n++;
      end
      bus.stall = 0; bus.save_req = 0; bus.restore_req = 0;
      chk("rand_done_seen", done_cnt != n0, 1);
      repeat (2) @(negedge clk);
      chk("rand_starts", starts, 1);
      chk_order();
      chk_banks();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
